// File: rtl/wb_spi_slave_if.sv
// Wishbone register port and SPI pins of wb_spi_slave grouped as one bundle.
// The master modport is the SoC/external side; the slave modport is the responder.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        intr;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  spi_sck, spi_mosi, spi_cs_n,
    output wb_dat_o, wb_ack_o, spi_miso, spi_miso_oe, intr
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output spi_sck, spi_mosi, spi_cs_n,
    input  wb_dat_o, wb_ack_o, spi_miso, spi_miso_oe, intr
  );
endinterface

// File: rtl/wb_spi_slave.sv
// SPI mode-0 byte responder with a Wishbone register port; SPI pins oversampled in clk.
// Optional interrupt logic is built when SPI_SLAVE_IRQ_EN is defined.
module wb_spi_slave #(
  parameter logic [7:0] dummy_byte = 8'hFF
) (
  input logic           clk,
  input logic           rst,
  wb_spi_slave_if.slave bus
);

  logic       sck_meta_r, sck_sync_r, sck_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic [7:0] shreg_r, shreg_n;
  logic [2:0] bit_cnt_r, bit_cnt_n;
  logic       miso_r, miso_n;
  logic [7:0] rx_hold_r, rx_hold_n, tx_hold_r, tx_hold_n;
  logic       rx_full_r, rx_full_n, tx_full_r, tx_full_n, ovr_r, ovr_n;
  logic       ack_r;
  logic [31:0] dat_o_r, rdata_s, ctrl_rd_s;
  logic       sck_rise_s, sck_fall_s, cs_start_s, byte_done_s, load_s;
  logic       access_s, rd_s, wr_s, pop_s, tx_wr_s, ovr_clr_s;
  logic [1:0] reg_sel_s;
  logic [7:0] byte_s, load_byte_s;
  logic       unused_s;

  // Two-flop synchronisers plus edge history; chip select is kept active-high so reset means idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_prev_r  <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      cs_meta_r   <= 1'b0;
      cs_sync_r   <= 1'b0;
      cs_prev_r   <= 1'b0;
    end else begin
      sck_meta_r  <= bus.spi_sck;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      mosi_meta_r <= bus.spi_mosi;
      mosi_sync_r <= mosi_meta_r;
      cs_meta_r   <= ~bus.spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
    end
  end

  assign sck_rise_s  = sck_sync_r & ~sck_prev_r & cs_sync_r;
  assign sck_fall_s  = ~sck_sync_r & sck_prev_r & cs_sync_r;
  assign cs_start_s  = cs_sync_r & ~cs_prev_r;
  assign byte_s      = {shreg_r[6:0], mosi_sync_r};
  assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);
  assign load_s      = cs_start_s | byte_done_s;
  assign load_byte_s = tx_full_r ? tx_hold_r : dummy_byte;

  assign access_s  = bus.wb_stb_i & bus.wb_cyc_i & ~ack_r;
  assign rd_s      = access_s & ~bus.wb_we_i;
  assign wr_s      = access_s & bus.wb_we_i;
  assign reg_sel_s = bus.wb_adr_i[3:2];
  assign pop_s     = rd_s & (reg_sel_s == 2'd0);
  assign tx_wr_s   = wr_s & (reg_sel_s == 2'd1);
  assign ovr_clr_s = wr_s & (reg_sel_s == 2'd2) & bus.wb_dat_i[2];

  // Shift engine: shift in on SCK rise, present the next MISO bit on SCK fall
  always_comb begin
    shreg_n   = shreg_r;
    bit_cnt_n = bit_cnt_r;
    miso_n    = miso_r;
    if (!cs_sync_r) begin
      bit_cnt_n = 3'd0;
      miso_n    = 1'b0;
    end else if (load_s) begin
      shreg_n   = load_byte_s;
      bit_cnt_n = 3'd0;
      miso_n    = load_byte_s[7];
    end else if (sck_rise_s) begin
      shreg_n   = byte_s;
      bit_cnt_n = bit_cnt_r + 3'd1;
    end else if (sck_fall_s && (bit_cnt_r != 3'd0)) begin
      miso_n    = shreg_r[7];
    end else begin
      miso_n    = miso_r;
    end
  end

  // Receive holding register, overrun flag and transmit holding register
  always_comb begin
    rx_hold_n = rx_hold_r;
    rx_full_n = rx_full_r;
    ovr_n     = ovr_clr_s ? 1'b0 : ovr_r;
    tx_hold_n = tx_hold_r;
    tx_full_n = tx_full_r;
    if (byte_done_s) begin
      if (!rx_full_r || pop_s) begin
        rx_hold_n = byte_s;
        rx_full_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (pop_s) begin
      rx_full_n = 1'b0;
    end else begin
      rx_full_n = rx_full_r;
    end
    // A write racing a load keeps the new byte; the load already used the old state
    if (tx_wr_s) begin
      tx_hold_n = bus.wb_dat_i[7:0];
      tx_full_n = 1'b1;
    end else if (load_s) begin
      tx_full_n = 1'b0;
    end else begin
      tx_full_n = tx_full_r;
    end
  end

  // Register read multiplexer
  always_comb begin
    case (reg_sel_s)
      2'd0:    rdata_s = {24'd0, rx_hold_r};
      2'd2:    rdata_s = {28'd0, cs_sync_r, ovr_r, ~tx_full_r, rx_full_r};
      2'd3:    rdata_s = ctrl_rd_s;
      default: rdata_s = 32'd0;
    endcase
  end

  // State registers and registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r   <= 8'd0;
      bit_cnt_r <= 3'd0;
      miso_r    <= 1'b0;
      rx_hold_r <= 8'd0;
      rx_full_r <= 1'b0;
      ovr_r     <= 1'b0;
      tx_hold_r <= 8'd0;
      tx_full_r <= 1'b0;
      ack_r     <= 1'b0;
      dat_o_r   <= 32'd0;
    end else begin
      shreg_r   <= shreg_n;
      bit_cnt_r <= bit_cnt_n;
      miso_r    <= miso_n;
      rx_hold_r <= rx_hold_n;
      rx_full_r <= rx_full_n;
      ovr_r     <= ovr_n;
      tx_hold_r <= tx_hold_n;
      tx_full_r <= tx_full_n;
      ack_r     <= access_s;
      dat_o_r   <= rd_s ? rdata_s : 32'd0;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic rx_ie_r, tx_ie_r, intr_r;

  // Interrupt enables and the registered level interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ie_r <= 1'b0;
      tx_ie_r <= 1'b0;
      intr_r  <= 1'b0;
    end else begin
      if (wr_s && (reg_sel_s == 2'd3)) begin
        rx_ie_r <= bus.wb_dat_i[0];
        tx_ie_r <= bus.wb_dat_i[1];
      end else begin
        rx_ie_r <= rx_ie_r;
        tx_ie_r <= tx_ie_r;
      end
      intr_r <= (rx_ie_r & rx_full_r) | (tx_ie_r & ~tx_full_r) | ovr_r;
    end
  end

  assign ctrl_rd_s = {30'd0, tx_ie_r, rx_ie_r};
  assign bus.intr  = intr_r;
`else
  assign ctrl_rd_s = 32'd0;
  assign bus.intr  = 1'b0;
`endif

  assign bus.wb_ack_o    = ack_r;
  assign bus.wb_dat_o    = dat_o_r;
  assign bus.spi_miso    = miso_r;
  assign bus.spi_miso_oe = cs_sync_r;
  assign unused_s = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0], bus.wb_dat_i[31:8]};

endmodule
